// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: state encoding and sizing helper shared by the divider files
package seq_divider_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;
  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/seq_divider_step.sv
// seq_divider_step: one combinational restoring-division iteration
module seq_divider_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] rs, t;
  // the partial remainder stays below d, so r_next always fits in WIDTH bits
  always_comb begin
    rs = {r, q[WIDTH-1]};
    t = rs - {1'b0, d};
    r_next = t[WIDTH] ? rs[WIDTH-1:0] : t[WIDTH-1:0];
    q_next = {q[WIDTH-2:0], ~t[WIDTH]};
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider with start/done handshake
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);
  localparam int CNT_W = cnt_w(WIDTH);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] r, q, d, r_next, q_next;
  seq_divider_step #(.WIDTH(WIDTH)) u_step (
    .r(r), .q(q), .d(d), .r_next(r_next), .q_next(q_next)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      r <= '0;
      q <= '0;
      d <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      quot <= '0;
      rem <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          d <= divisor;
          r <= '0;
          q <= dividend;
          cnt <= '0;
          busy <= 1'b1;
          if (divisor == '0) begin
            state <= S_DONE;
            done <= 1'b1;
            quot <= '1;
            rem <= dividend;
            div_zero <= 1'b1;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          r <= r_next;
          q <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= S_DONE;
            done <= 1'b1;
            quot <= q_next;
            rem <= r_next;
            div_zero <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and model-checked bench for seq_divider at WIDTH 4 and 8
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start4 = 1'b0, busy4, done4, z4;
  logic [3:0] a4 = '0, b4 = '0, q4, r4;
  logic start8 = 1'b0, busy8, done8, z8;
  logic [7:0] a8 = '0, b8 = '0, q8, r8;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  seq_divider #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .dividend(a4), .divisor(b4),
    .busy(busy4), .done(done4), .quot(q4), .rem(r4), .div_zero(z4)
  );
  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(a8), .divisor(b8),
    .busy(busy8), .done(done8), .quot(q8), .rem(r8), .div_zero(z8)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  // drives one request in the first idle cycle; returns on the done cycle (or timeout)
  task automatic run4(input logic [3:0] a, input logic [3:0] b, output int lat, output int bcnt);
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b;
    @(negedge clk);
    start4 = 1'b0; a4 = ~a; b4 = ~b;
    lat = 1; bcnt = 0;
    while (!done4 && lat < 20) begin
      if (busy4) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (busy4) bcnt++;
  endtask
  task automatic div4(input logic [3:0] a, input logic [3:0] b);
    int lat, bcnt;
    run4(a, b, lat, bcnt);
    check($sformatf("lat4 %0d/%0d", a, b), lat, (b == 0) ? 1 : 5);
    check($sformatf("busy4 %0d/%0d", a, b), bcnt, lat);
    check($sformatf("quot4 %0d/%0d", a, b), q4, (b == 0) ? 15 : a / b);
    check($sformatf("rem4 %0d/%0d", a, b), r4, (b == 0) ? a : a % b);
    check($sformatf("dz4 %0d/%0d", a, b), z4, b == 0);
  endtask
  task automatic div8(input logic [7:0] a, input logic [7:0] b);
    int lat;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0; a8 = $urandom_range(0, 255); b8 = $urandom_range(0, 255);
    lat = 1;
    while (!done8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("lat8 %0d/%0d", a, b), lat, (b == 0) ? 1 : 9);
    check($sformatf("quot8 %0d/%0d", a, b), q8, (b == 0) ? 255 : a / b);
    check($sformatf("rem8 %0d/%0d", a, b), r8, (b == 0) ? a : a % b);
    check($sformatf("dz8 %0d/%0d", a, b), z8, b == 0);
  endtask
  initial begin
    int lat, bcnt, dones;
    logic [7:0] ra, rb;
    repeat (2) @(negedge clk);
    check("rst busy", busy4, 0);
    check("rst done", done4, 0);
    check("rst quot", q4, 0);
    check("rst rem", r4, 0);
    check("rst dz", z4, 0);
    rst_n = 1'b1;
    div4(13, 4);
    @(negedge clk);
    check("idle busy after 13/4", busy4, 0);
    check("idle done after 13/4", done4, 0);
    check("hold quot 13/4", q4, 3);
    div4(15, 1);
    div4(0, 5);
    div4(3, 9);
    div4(15, 15);
    div4(7, 0);
    div4(9, 2);
    // start pulses during CALC must be ignored and must not disturb operands
    @(negedge clk);
    start4 = 1'b1; a4 = 13; b4 = 4;
    dones = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (done4) dones++;
      start4 = (c >= 1 && c <= 3);
      a4 = 6; b4 = 3;
      if (c == 5) begin
        start4 = 1'b0;
        check("busy-start done", done4, 1);
        check("busy-start quot", q4, 3);
        check("busy-start rem", r4, 1);
      end
    end
    repeat (8) begin
      @(negedge clk);
      if (done4) dones++;
    end
    check("busy-start done count", dones, 1);
    // reset mid-operation
    @(negedge clk);
    start4 = 1'b1; a4 = 13; b4 = 4;
    repeat (3) @(negedge clk);
    start4 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort busy", busy4, 0);
    check("abort done", done4, 0);
    check("abort quot", q4, 0);
    check("abort rem", r4, 0);
    check("abort dz", z4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done4 || busy4) dones++;
    end
    check("abort no activity", dones, 0);
    run4(6, 3, lat, bcnt);
    check("post-abort lat", lat, 5);
    check("post-abort quot", q4, 2);
    check("post-abort rem", r4, 0);
    for (int i = 0; i < 256; i++) div4(4'(i >> 4), 4'(i));
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      div8(ra, rb);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
